// File: rtl/led_blinker_bank.sv
// rtl/led_blinker_bank.sv - NCH-channel LED heartbeat/lamp/one-shot generator on a shared tick
module led_blinker_bank #(
  parameter int NCH      = 4,
  parameter int PRESCALE = 100000,
  parameter int PW       = 16,
  parameter int RST_HALF = 500,
  localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int PSW     = $clog2(PRESCALE)
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [1:0]     cfg_mode,
  input  logic [PW-1:0]  cfg_half,
  input  logic           sync,
  output logic           tick,
  output logic [NCH-1:0] led,
  output logic [NCH-1:0] done
);

  localparam logic [1:0] MODE_OFF     = 2'b00;
  localparam logic [1:0] MODE_ON      = 2'b01;
  localparam logic [1:0] MODE_BLINK   = 2'b10;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;

  logic [PSW-1:0] pcnt;
  logic [1:0]     mode [NCH];
  logic [PW-1:0]  half [NCH];
  logic [PW-1:0]  cnt  [NCH];
  logic [NCH-1:0] term;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else if (sync) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == PSW'(PRESCALE - 1));
      pcnt <= (pcnt == PSW'(PRESCALE - 1)) ? '0 : pcnt + 1'b1;
    end
  end

  // A half-period of 0 behaves as 1, so the terminal count is max(half,1)-1.
  always_comb begin
    term = '0;
    for (int i = 0; i < NCH; i++) begin
      term[i] = (half[i] == '0) ? 1'b1 : (cnt[i] >= half[i] - 1'b1);
    end
  end

  // Priority per channel: config write, then sync, then the tick-driven count.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        mode[i] <= MODE_OFF;
        half[i] <= PW'(RST_HALF);
        cnt[i]  <= '0;
      end
      led  <= '0;
      done <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        done[i] <= 1'b0;
        if (cfg_we && (cfg_ch == CW'(i))) begin
          mode[i] <= cfg_mode;
          half[i] <= cfg_half;
          cnt[i]  <= '0;
          led[i]  <= (cfg_mode != MODE_OFF);
        end else if (sync) begin
          cnt[i] <= '0;
          if (mode[i] == MODE_BLINK) led[i] <= 1'b1;
        end else if (tick) begin
          case (mode[i])
            MODE_BLINK: begin
              if (term[i]) begin
                cnt[i] <= '0;
                led[i] <= ~led[i];
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
            MODE_ONESHOT: begin
              if (term[i]) begin
                cnt[i]  <= '0;
                led[i]  <= 1'b0;
                mode[i] <= MODE_OFF;
                done[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] + 1'b1;
              end
            end
            MODE_ON, MODE_OFF: begin
              cnt[i] <= cnt[i];
            end
            default: begin
              cnt[i] <= cnt[i];
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_led_blinker_bank.sv
// tb/tb_led_blinker_bank.sv - directed bench for led_blinker_bank (PRESCALE=4, NCH=4, PW=8)
module tb_led_blinker_bank;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       cfg_we;
  logic [1:0] cfg_ch;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_half;
  logic       sync;
  logic       tick;
  logic [3:0] led;
  logic [3:0] done;

  logic       cfg5_we;
  logic [2:0] cfg5_ch;
  logic [1:0] cfg5_mode;
  logic [7:0] cfg5_half;
  logic       tick5;
  logic [4:0] led5;
  logic [4:0] done5;

  int n_chk = 0;
  int n_err = 0;
  int cyc_n = 0;

  led_blinker_bank #(.NCH(4), .PRESCALE(4), .PW(8), .RST_HALF(10)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_mode(cfg_mode), .cfg_half(cfg_half), .sync(sync),
    .tick(tick), .led(led), .done(done)
  );

  // Five channels give a 3-bit cfg_ch, so channel numbers 5 and 7 are representable.
  led_blinker_bank #(.NCH(5), .PRESCALE(4), .PW(8), .RST_HALF(10)) dut5 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cfg_we(cfg5_we), .cfg_ch(cfg5_ch),
    .cfg_mode(cfg5_mode), .cfg_half(cfg5_half), .sync(1'b0),
    .tick(tick5), .led(led5), .done(done5)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk);
    cyc_n++;
  endtask

  task automatic to_cyc(input int n);
    while (cyc_n < n) cyc();
  endtask

  task automatic cfg(input logic [1:0] ch, input logic [1:0] mode, input logic [7:0] half);
    cfg_we = 1'b1; cfg_ch = ch; cfg_mode = mode; cfg_half = half;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic cfg5(input logic [2:0] ch, input logic [1:0] mode);
    cfg5_we = 1'b1; cfg5_ch = ch; cfg5_mode = mode; cfg5_half = 8'd2;
    cyc();
    cfg5_we = 1'b0;
  endtask

  initial begin
    sys_rst_n = 1'b0;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mode = '0; cfg_half = '0; sync = 1'b0;
    cfg5_we = 1'b0; cfg5_ch = '0; cfg5_mode = '0; cfg5_half = '0;
    repeat (3) @(negedge sys_clk);
    chk("rst_led", led, 4'b0000);
    chk("rst_done", done, 4'b0000);
    chk("rst_tick", tick, 1'b0);
    chk("rst_led5", led5, 5'b00000);

    sys_rst_n = 1'b1;
    cyc_n = 0;
    to_cyc(3);  chk("tick_c3", tick, 1'b0);
    to_cyc(4);  chk("tick_c4", tick, 1'b1);
    to_cyc(5);  chk("tick_c5", tick, 1'b0);
    chk("led_idle", led, 4'b0000);

    cfg(2'd0, 2'b10, 8'd3);  chk("ch0_blink_on", led, 4'b0001);
    cfg(2'd3, 2'b01, 8'd0);  chk("ch3_on", led, 4'b1001);
    cfg(2'd2, 2'b10, 8'd0);  chk("ch2_blink_on", led, 4'b1101);
    chk("tick_c8", tick, 1'b1);
    cfg(2'd1, 2'b11, 8'd2);  chk("ch1_oneshot_on", led, 4'b1011);
    chk("tick_c9", tick, 1'b0);

    to_cyc(13); chk("led_c13", led, 4'b1111);
    to_cyc(16); chk("led_c16", led, 4'b1111);
    chk("done_c16", done, 4'b0000);
    to_cyc(17); chk("led_c17", led, 4'b1000);
    chk("done_c17", done, 4'b0010);
    to_cyc(18); chk("done_c18", done, 4'b0000);
    chk("led_c18", led, 4'b1000);
    to_cyc(21); chk("led_c21", led, 4'b1100);
    to_cyc(29); chk("led_c29", led, 4'b1101);

    cfg(2'd2, 2'b10, 8'd5);  chk("ch2_half5", led, 4'b1101);
    to_cyc(50); chk("led_pre_sync", led, 4'b1000);
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("led_sync", led, 4'b1101);
    chk("tick_sync", tick, 1'b0);
    to_cyc(52); chk("tick_c52", tick, 1'b0);
    to_cyc(54); chk("tick_c54", tick, 1'b0);
    to_cyc(55); chk("tick_c55", tick, 1'b1);
    to_cyc(63); chk("led_c63", led, 4'b1101);
    to_cyc(64); chk("led_c64", led, 4'b1100);
    to_cyc(71); chk("led_c71", led, 4'b1100);
    chk("tick_c71", tick, 1'b1);

    #2 sys_rst_n = 1'b0;
    #1;
    chk("async_led", led, 4'b0000);
    chk("async_tick", tick, 1'b0);
    chk("async_done", done, 4'b0000);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    cfg5(3'd5, 2'b01); chk("oob_ch5", led5, 5'b00000);
    cfg5(3'd7, 2'b01); chk("oob_ch7", led5, 5'b00000);
    cfg5(3'd4, 2'b01); chk("ch4_on", led5, 5'b10000);
    chk("main_after_rst", led, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
